tristate_bus_arbiter: RTL and testbench
=======================================

# tristate_bus_arbiter

- Round-robin arbiter for a shared three-state bus.
- Generates the per-requester active-low drive enables for the upstream mux-plus-tri-state-buffer stages, so at most one stage drives the bus in any cycle.
- Inserts a one-cycle all-released turnaround between owners.
- Captures the bus value only while an owner is driving.
- Sits between the requesting datapath stages and the bus consumer.

## Interface
Parameters:
- NREQ, 4, number of requesters/three-state drivers (2..8)
- W, 8, bus width
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership (≥1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- req  input  NREQ  request to own the bus, level-sensitive, one bit per requester
- done  input  NREQ  owner releases the bus; only the current owner's bit is honoured
- bus  input  W  shared three-state bus line as seen by the consumer
- enable_n  output  NREQ  active-low drive enable per driver stage; 0 = drive, 1 = high-Z
- grant  output  NREQ  one-hot grant, equal to ~enable_n
- owner  output  clog2(NREQ)  index of current or last owner
- bus_valid  output  1  an owner is driving the bus this cycle
- data_q  output  W  last captured bus value
- data_valid  output  1  one-cycle strobe: data_q updated at the previous edge

## Operation
- All outputs are registered.
- FSM states: IDLE, GRANT, TURN.
- Reset values after any edge with rst=1:
  - enable_n = all 1s, grant = 0, bus_valid = 0
  - owner = 0, data_q = 0, data_valid = 0
  - state = IDLE, hold counter = 0
  - round-robin pointer = NREQ-1, so requester 0 has first priority
- Arbitration:
  - Search starts at (pointer+1) mod NREQ and selects the first set req bit, wrapping.
  - On grant, pointer and owner are set to the winner.
- IDLE:
  - If any req bit is set → GRANT with the selected winner.
  - Otherwise stay in IDLE with everything released.
- GRANT:
  - enable_n[owner] = 0, all other enable_n bits = 1, bus_valid = 1.
  - Hold counter increments every GRANT cycle.
  - Exit to TURN at the edge where done[owner]=1, or req[owner]=0, or hold counter = MAX_HOLD-1.
  - On exit, enable_n returns to all 1s and the hold counter clears.
  - Requests and done bits from non-owners are ignored.
- TURN:
  - Exactly one cycle, all enable_n = 1, bus_valid = 0.
  - Arbitration is evaluated in this cycle: any req → GRANT (the previous owner is eligible only if no other requester is asserting), else IDLE.
- Capture:
  - At each edge where bus_valid=1: data_q ← bus and data_valid ← 1.
  - Otherwise data_valid ← 0 and data_q holds its value.
  - The bus is never sampled while released (high-Z/X).
- Invariants:
  - grant is always one-hot or zero.
  - enable_n never has more than one 0.
  - enable_n is never 0 for two different drivers on consecutive cycles.

## Timing
- Request-to-drive latency from IDLE: req seen high at edge k → enable_n low from edge k (visible the cycle after k).
- Handover:
  - The release edge is followed by exactly one TURN cycle.
  - The next owner drives from the following edge.
  - Minimum gap between owners is 1 cycle.
- Continuous contention: each ownership lasts MAX_HOLD cycles plus 1 turnaround; full rotation = NREQ×(MAX_HOLD+1) cycles.
- done and req dropped on the same edge: single release, one TURN.
- done asserted in the first GRANT cycle gives a 1-cycle ownership.
- MAX_HOLD=1: every grant lasts exactly 1 cycle.
- Capture latency: data_q and data_valid reflect the bus 1 cycle after each driven cycle. The last data_valid pulse of an ownership falls in the TURN cycle.
- rst mid-GRANT: all drivers release at that edge with no TURN cycle; rst has priority over all other inputs.

## Test plan
- Reset with req=4'hF held → after the rst edge: enable_n=4'b1111, grant=0, bus_valid=0, owner=0, data_valid=0, data_q=0; after rst release, first grant goes to 0.
- req=4'b0100 for 3 cycles, then 0 → grant=4'b0100 and enable_n=4'b1011 for 3 cycles, then one cycle of 4'b1111, then IDLE (no further grants).
- req=4'b1111 held, MAX_HOLD=8 → owners 0,1,2,3,0, each driving 8 cycles separated by one all-1s cycle; period 36 cycles; never two zero bits in enable_n.
- Owner 1 pulses done in its 2nd grant cycle while req=4'b0011 → ownership lasts 2 cycles, TURN, then owner 0 (wrap-around), not owner 1.
- Driven owner puts 8'hA5 then 8'h3C on bus, W=8 → data_q=8'hA5 then 8'h3C with data_valid high; during IDLE the bus is Z and data_q stays 8'h3C with data_valid=0.
- rst asserted in the 4th grant cycle of owner 2 → enable_n=4'b1111 immediately after that edge, owner=0, state IDLE; after release, with req=4'b0100 pending, owner 2 is granted 1 cycle later.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter
//   Round-robin owner selection for a shared three-state bus. Produces the
//   active-low drive enables for the upstream tri-state driver stages, keeps
//   at most one driver active, inserts a one-cycle all-released turnaround
//   between owners and captures the bus only while an owner is driving.
//
// Parameters
//   NREQ      number of requesters / three-state drivers (2..8)
//   W         bus width
//   MAX_HOLD  maximum consecutive grant cycles per ownership (>= 1)
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset, priority over all inputs
//   req         level request per requester
//   done        release request; only the current owner's bit is honoured
//   bus         shared bus as seen by the consumer
//   enable_n    active-low drive enable per driver stage (registered)
//   grant       one-hot grant, always ~enable_n (registered)
//   owner       index of current or last owner (registered)
//   bus_valid   an owner drives the bus this cycle (registered)
//   data_q      last captured bus value (registered)
//   data_valid  one-cycle strobe, data_q updated at the previous edge
// -----------------------------------------------------------------------------
module tristate_bus_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NREQ-1:0]                       req,
    input  logic [NREQ-1:0]                       done,
    input  logic [W-1:0]                          bus,
    output logic [NREQ-1:0]                       enable_n,
    output logic [NREQ-1:0]                       grant,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner,
    output logic                                  bus_valid,
    output logic [W-1:0]                          data_q,
    output logic                                  data_valid
);

    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t         state;
    logic [OW-1:0]  ptr;
    logic [HW-1:0]  hold;

    logic [OW-1:0]   win_c;
    logic            found_c;
    logic [NREQ-1:0] win_oh_c;
    logic            any_req_c;
    logic            release_c;
    int unsigned     cand;

    // Round-robin pick: first set req bit starting just after the pointer.
    // The pointer's own requester is therefore considered last.
    always_comb begin
        win_c   = ptr;
        found_c = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(ptr) + i + 32'd1;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found_c && req[OW'(cand)]) begin
                win_c   = OW'(cand);
                found_c = 1'b1;
            end
        end
    end

    assign any_req_c = |req;
    assign win_oh_c  = NREQ'(1) << win_c;

    // Ownership ends on the owner's done, a dropped request, or the hold limit.
    assign release_c = done[owner] || !req[owner] || (hold == HW'(MAX_HOLD - 1));

    // Ownership FSM with registered enables, grant and capture path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= OW'(NREQ - 1);
            hold       <= '0;
            enable_n   <= '1;
            grant      <= '0;
            owner      <= '0;
            bus_valid  <= 1'b0;
            data_q     <= '0;
            data_valid <= 1'b0;
        end else begin
            // Capture only cycles in which an owner was driving.
            data_valid <= bus_valid;
            if (bus_valid) begin
                data_q <= bus;
            end

            case (state)
                IDLE, TURN: begin
                    if (any_req_c) begin
                        state     <= GRANT;
                        ptr       <= win_c;
                        owner     <= win_c;
                        grant     <= win_oh_c;
                        enable_n  <= ~win_oh_c;
                        bus_valid <= 1'b1;
                        hold      <= '0;
                    end else begin
                        state     <= IDLE;
                        grant     <= '0;
                        enable_n  <= '1;
                        bus_valid <= 1'b0;
                        hold      <= '0;
                    end
                end

                GRANT: begin
                    if (release_c) begin
                        // Turnaround: every driver released for one cycle.
                        state     <= TURN;
                        grant     <= '0;
                        enable_n  <= '1;
                        bus_valid <= 1'b0;
                        hold      <= '0;
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    enable_n  <= '1;
                    bus_valid <= 1'b0;
                    hold      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tristate_bus_arbiter
//   Directed stimulus; expected grant and capture events are queued with the
//   cycle they must appear in, and a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_tristate_bus_arbiter;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned W        = 8;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned OW       = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic [W-1:0]    bus;
    logic [NREQ-1:0] enable_n;
    logic [NREQ-1:0] grant;
    logic [OW-1:0]   owner;
    logic            bus_valid;
    logic [W-1:0]    data_q;
    logic            data_valid;

    logic [W-1:0]    drv [NREQ];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int              c;
        logic [OW-1:0]   o;
        logic [NREQ-1:0] en;
    } g_t;

    typedef struct {
        int           c;
        logic [W-1:0] d;
    } d_t;

    g_t exp_g[$];
    d_t exp_d[$];

    tristate_bus_arbiter #(
        .NREQ     (NREQ),
        .W        (W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .bus        (bus),
        .enable_n   (enable_n),
        .grant      (grant),
        .owner      (owner),
        .bus_valid  (bus_valid),
        .data_q     (data_q),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Driver stages: released bus floats; modelled as a junk pattern.
    always_comb begin
        bus = 8'hEE;
        for (int i = 0; i < NREQ; i++) begin
            if (!enable_n[i]) bus = drv[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grants(input int start, input int own, input int count);
        g_t e;
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << own;
        for (int k = 0; k < count; k++) begin
            e.c  = start + k;
            e.o  = OW'(own);
            e.en = ~oh;
            exp_g.push_back(e);
        end
    endtask

    task automatic push_data(input int start, input logic [W-1:0] val, input int count);
        d_t e;
        for (int k = 0; k < count; k++) begin
            e.c = start + k;
            e.d = val;
            exp_d.push_back(e);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_enable_n"},  32'(enable_n),  32'hF);
        chk({name, "_grant"},     32'(grant),     32'h0);
        chk({name, "_bus_valid"}, 32'(bus_valid), 32'h0);
    endtask

    // Monitor: invariants every cycle, scoreboard pops on valid strobes.
    initial begin : monitor
        logic [NREQ-1:0] prev;
        logic [NREQ-1:0] inv_en;
        g_t eg;
        d_t ed;
        prev = '0;
        forever begin
            @(negedge clk);
            inv_en = ~enable_n;
            chk("grant_eq_not_enable", 32'(grant), 32'(inv_en));
            chk("grant_onehot0", 32'($onehot0(grant)), 32'h1);
            chk("bus_valid_vs_grant", 32'(bus_valid), 32'(|grant));
            chk("no_direct_handover",
                32'((grant != '0) && (prev != '0) && (grant != prev)), 32'h0);
            prev = grant;

            if (bus_valid) begin
                if (exp_g.size() == 0) begin
                    chk("unexpected_grant_owner", 32'(owner), 32'hFFFF_FFFF);
                end else begin
                    eg = exp_g.pop_front();
                    chk("grant_cycle", 32'(cyc), 32'(eg.c));
                    chk("grant_owner", 32'(owner), 32'(eg.o));
                    chk("grant_enable_n", 32'(enable_n), 32'(eg.en));
                end
            end

            if (data_valid) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_capture_data", 32'(data_q), 32'hFFFF_FFFF);
                end else begin
                    ed = exp_d.pop_front();
                    chk("capture_cycle", 32'(cyc), 32'(ed.c));
                    chk("capture_data", 32'(data_q), 32'(ed.d));
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        drv[0] = 8'h11;
        drv[1] = 8'h22;
        drv[2] = 8'h33;
        drv[3] = 8'h44;

        // Reset with all requests held.
        rst  = 1'b1;
        req  = 4'hF;
        done = 4'h0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_owner",      32'(owner),      32'h0);
        chk("reset_data_valid", 32'(data_valid), 32'h0);
        chk("reset_data_q",     32'(data_q),     32'h0);

        // Continuous contention: owners 0,1,2,3,0, 8 cycles each, 9-cycle period.
        n = cyc;
        for (int k = 0; k < 5; k++) begin
            push_grants(n + 1 + 9 * k, k % 4, 8);
            push_data(n + 2 + 9 * k, drv[k % 4], 8);
        end
        rst = 1'b0;
        repeat (44) tick();
        req = 4'h0;
        tick();
        tick();
        chk_idle("rotation_end");
        chk("rotation_last_owner", 32'(owner), 32'h0);

        // Single requester for three cycles, then turnaround and idle.
        n = cyc;
        push_grants(n + 1, 2, 3);
        push_data(n + 2, drv[2], 3);
        req = 4'b0100;
        repeat (3) tick();
        req = 4'b0000;
        tick();
        chk_idle("single_turn");
        chk("single_turn_data_valid", 32'(data_valid), 32'h1);
        repeat (3) tick();
        chk_idle("single_idle");
        chk("single_idle_owner", 32'(owner), 32'h2);

        // Owner 1 releases via done in its second cycle; wrap to owner 0.
        n = cyc;
        push_grants(n + 1, 1, 2);
        push_data(n + 2, drv[1], 2);
        push_grants(n + 4, 0, 2);
        push_data(n + 5, drv[0], 2);
        req = 4'b0010;
        tick();
        req = 4'b0011;
        tick();
        done = 4'b0010;
        tick();
        done = 4'b0000;
        chk_idle("done_turn");
        tick();
        done = 4'b0010;          // non-owner done must be ignored
        tick();
        req  = 4'b0000;          // done and req drop together
        done = 4'b0001;
        tick();
        done = 4'b0000;
        chk_idle("done_req_turn");
        repeat (3) tick();
        chk_idle("done_idle");

        // Capture: A5 then 3C; held through idle.
        n = cyc;
        push_grants(n + 1, 0, 2);
        push_data(n + 2, 8'hA5, 1);
        push_data(n + 3, 8'h3C, 1);
        drv[0] = 8'hA5;
        req = 4'b0001;
        tick();
        tick();
        drv[0] = 8'h3C;
        req = 4'b0000;
        repeat (3) tick();
        chk_idle("capture_idle");
        chk("capture_idle_data_q",     32'(data_q),     32'h3C);
        chk("capture_idle_data_valid", 32'(data_valid), 32'h0);

        // done in the first grant cycle: one-cycle ownership.
        n = cyc;
        push_grants(n + 1, 2, 1);
        push_data(n + 2, drv[2], 1);
        req = 4'b0100;
        tick();
        done = 4'b0100;
        tick();
        req  = 4'b0000;
        done = 4'b0000;
        chk_idle("first_cycle_done_turn");
        repeat (3) tick();

        // Reset in owner 2's fourth grant cycle; regrant right after release.
        n = cyc;
        push_grants(n + 1, 2, 4);
        push_data(n + 2, drv[2], 3);
        req = 4'b0100;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk_idle("midgrant_reset");
        chk("midgrant_reset_owner",      32'(owner),      32'h0);
        chk("midgrant_reset_data_valid", 32'(data_valid), 32'h0);
        chk("midgrant_reset_data_q",     32'(data_q),     32'h0);
        n = cyc;
        push_grants(n + 1, 2, 1);
        push_data(n + 2, drv[2], 1);
        rst = 1'b0;
        tick();
        chk("post_reset_owner", 32'(owner), 32'h2);
        req = 4'b0000;
        repeat (4) tick();
        chk_idle("final_idle");

        chk("grant_queue_drained", 32'(exp_g.size()), 32'h0);
        chk("data_queue_drained",  32'(exp_d.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
